// File: rtl/ppu_pkg.sv
// Shared sizing and beat types for the posit divider back end.
// N=16, ES=1 gives a 41-bit quotient mantissa and a 6-bit te.
package ppu_pkg;

  localparam int N          = 16;
  localparam int ES         = 1;
  localparam int MANT_SIZE  = N - 2;
  localparam int MANT_DIV_W = 3 * MANT_SIZE - 1;
  localparam int FRAC_W     = MANT_SIZE - 1;
  localparam int TE_SIZE    = ES + $clog2(N) + 1;
  localparam int TE_MAX     = (N - 2) << ES;
  localparam int TE_MIN     = -TE_MAX;

  typedef struct packed {
    logic [MANT_DIV_W-1:0]     mant;
    logic signed [TE_SIZE-1:0] te;
    logic                      sign;
    logic                      zero;
    logic                      nar;
  } div_beat_t;

  typedef struct packed {
    logic [FRAC_W-1:0]         frac;
    logic signed [TE_SIZE-1:0] te;
    logic                      sign;
    logic                      zero;
    logic                      nar;
  } div_res_t;

endpackage

// File: rtl/div_round_stage_if.sv
// Valid/ready bundle between the divider core, the round stage
// and the posit encoder.
interface div_round_stage_if;
  import ppu_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [MANT_DIV_W-1:0]     in_mant;
  logic signed [TE_SIZE-1:0] in_te;
  logic                      in_sign;
  logic                      in_zero;
  logic                      in_nar;

  logic                      out_valid;
  logic                      out_ready;
  logic [FRAC_W-1:0]         out_frac;
  logic signed [TE_SIZE-1:0] out_te;
  logic                      out_sign;
  logic                      out_zero;
  logic                      out_nar;

  modport master (
    output in_valid, in_mant, in_te,
    output in_sign, in_zero, in_nar,
    input  in_ready,
    input  out_valid, out_frac, out_te,
    input  out_sign, out_zero, out_nar,
    output out_ready
  );

  modport slave (
    input  in_valid, in_mant, in_te,
    input  in_sign, in_zero, in_nar,
    output in_ready,
    output out_valid, out_frac, out_te,
    output out_sign, out_zero, out_nar,
    input  out_ready
  );

endinterface

// File: rtl/rne_round.sv
// Round-to-nearest-even of the quotient mantissa, te carry,
// te clamp and special-value override.
module rne_round
  import ppu_pkg::*;
(
  input  logic [MANT_DIV_W-2:0]     mant,
  input  logic signed [TE_SIZE-1:0] te,
  input  logic                      sign,
  input  logic                      zero,
  input  logic                      nar,
  output div_res_t                  res
);

  localparam logic signed [TE_SIZE:0] HI =
    (TE_SIZE+1)'(TE_MAX);
  localparam logic signed [TE_SIZE:0] LO =
    (TE_SIZE+1)'(TE_MIN);

  logic [FRAC_W-1:0]         frac_t;
  logic                      g;
  logic                      st;
  logic                      up;
  logic [FRAC_W:0]           sum;
  logic signed [TE_SIZE:0]   te_x;

  assign frac_t = mant[MANT_DIV_W-2 -: FRAC_W];
  assign g      = mant[MANT_DIV_W-2-FRAC_W];
  assign st     = |mant[MANT_DIV_W-3-FRAC_W:0];
  assign up     = g & (st | frac_t[0]);

  // On carry the low FRAC_W bits of sum are already zero.
  assign sum  = {1'b0, frac_t} + {{FRAC_W{1'b0}}, up};
  assign te_x = {te[TE_SIZE-1], te}
              + {{TE_SIZE{1'b0}}, sum[FRAC_W]};

  always_comb begin
    res = '0;
    if (nar) begin
      res.nar = 1'b1;
    end else if (zero) begin
      res.zero = 1'b1;
    end else if (te_x >= HI) begin
      res.te   = HI[TE_SIZE-1:0];
      res.sign = sign;
    end else if (te_x <= LO) begin
      res.te   = LO[TE_SIZE-1:0];
      res.sign = sign;
    end else begin
      res.frac = sum[FRAC_W-1:0];
      res.te   = te_x[TE_SIZE-1:0];
      res.sign = sign;
    end
  end

endmodule

// File: rtl/div_round_stage.sv
// Elastic two-stage normalise/round/saturate pipe
// behind the divider core.
module div_round_stage
  import ppu_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  div_round_stage_if.slave io
);

  logic      s1_valid;
  div_beat_t s1_q;
  logic      out_valid_q;
  div_res_t  out_q;
  div_res_t  rnd;
  logic      s1_adv;
  logic      s2_adv;

  assign s2_adv      = ~out_valid_q | io.out_ready;
  assign s1_adv      = ~s1_valid | s2_adv;
  assign io.in_ready = s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= io.in_valid;
      if (io.in_valid) begin
        s1_q.mant <= io.in_mant;
        s1_q.te   <= io.in_te;
        s1_q.sign <= io.in_sign;
        s1_q.zero <= io.in_zero;
        s1_q.nar  <= io.in_nar;
      end
    end
  end

  rne_round u_rnd (
    .mant (s1_q.mant[MANT_DIV_W-2:0]),
    .te   (s1_q.te),
    .sign (s1_q.sign),
    .zero (s1_q.zero),
    .nar  (s1_q.nar),
    .res  (rnd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_q <= rnd;
      end
    end
  end

  assign io.out_valid = out_valid_q;
  assign io.out_frac  = out_q.frac;
  assign io.out_te    = out_q.te;
  assign io.out_sign  = out_q.sign;
  assign io.out_zero  = out_q.zero;
  assign io.out_nar   = out_q.nar;

  // The core always delivers a normalised quotient.
  a_hidden: assert property (
    @(posedge clk) disable iff (!rst_n)
    s1_valid |-> s1_q.mant[MANT_DIV_W-1]
  );

endmodule

// File: tb/tb_div_round_stage.sv
// Directed scoreboard bench for div_round_stage: rounding, carry,
// clamp, specials, backpressure and mid-flight reset.
module tb_div_round_stage;
  import ppu_pkg::*;

  typedef struct {
    int       id;
    div_res_t r;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_round_stage_if bus();

  div_round_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  exp_t     q[$];
  int       errors = 0;
  int       checks = 0;
  int       nid = 0;
  exp_t     me;
  div_res_t got;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      got = '{bus.out_frac, bus.out_te, bus.out_sign,
              bus.out_zero, bus.out_nar};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL stray_beat: got frac=%0h te=%0d, expected no beat",
                 got.frac, got.te);
      end else begin
        me = q.pop_front();
        if (got !== me.r) begin
          errors++;
          $display("FAIL beat%0d: got frac=%0h te=%0d s=%0b z=%0b n=%0b expected frac=%0h te=%0d s=%0b z=%0b n=%0b",
                   me.id, got.frac, got.te, got.sign, got.zero,
                   got.nar, me.r.frac, me.r.te, me.r.sign,
                   me.r.zero, me.r.nar);
        end
      end
    end
  end

  task automatic send(
    input logic [FRAC_W-1:0] ft, input logic g,
    input logic [MANT_DIV_W-3-FRAC_W:0] st, input int te,
    input logic s, input logic z, input logic n,
    input logic [FRAC_W-1:0] ef, input int ete,
    input logic es, input logic ez, input logic en,
    output int stalls);
    logic [MANT_DIV_W-1:0] m;
    exp_t e;
    m = '0;
    m[MANT_DIV_W-1] = 1'b1;
    m[MANT_DIV_W-2 -: FRAC_W] = ft;
    m[MANT_DIV_W-2-FRAC_W] = g;
    m[MANT_DIV_W-3-FRAC_W:0] = st;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_mant  = m;
    bus.in_te    = TE_SIZE'(te);
    bus.in_sign  = s;
    bus.in_zero  = z;
    bus.in_nar   = n;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.id = nid;
        e.r  = '{ef, TE_SIZE'(ete), es, ez, en};
        q.push_back(e);
        nid++;
        break;
      end
      stalls++;
      if (stalls >= 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout%0d: in_ready=0 after 100 cycles, expected 1",
                 nid);
        break;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("drain_left", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    int st;
    int tot;
    bus.in_valid  = 1'b0;
    bus.in_mant   = '0;
    bus.in_te     = '0;
    bus.in_sign   = 1'b0;
    bus.in_zero   = 1'b0;
    bus.in_nar    = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_frac", 64'(bus.out_frac), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

    // latency: exact 2 cycles from accept
    send(13'h0000, 1'b0, 26'h0, 3, 0, 0, 0,
         13'h0000, 3, 0, 0, 0, st);
    idle();
    @(negedge clk);
    chk("lat_cycle1", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk("lat_cycle2", 64'(bus.out_valid), 64'd1);
    drain();

    // full-rate burst
    tot = 0;
    send(13'h0002, 1'b1, 26'h0, 0, 0, 0, 0,
         13'h0002, 0, 0, 0, 0, st); tot += st;
    send(13'h0003, 1'b1, 26'h0, 0, 0, 0, 0,
         13'h0004, 0, 0, 0, 0, st); tot += st;
    send(13'h0002, 1'b1, 26'h1, 0, 0, 0, 0,
         13'h0003, 0, 0, 0, 0, st); tot += st;
    send(13'h0005, 1'b0, 26'h3FFFFFF, 2, 0, 0, 0,
         13'h0005, 2, 0, 0, 0, st); tot += st;
    send(13'h1FFF, 1'b1, 26'h0, 5, 0, 0, 0,
         13'h0000, 6, 0, 0, 0, st); tot += st;
    send(13'h1FFF, 1'b1, 26'h0, 27, 0, 0, 0,
         13'h0000, 28, 0, 0, 0, st); tot += st;
    send(13'h0ABC, 1'b0, 26'h0, 31, 0, 0, 0,
         13'h0000, 28, 0, 0, 0, st); tot += st;
    send(13'h0123, 1'b0, 26'h0, -32, 1, 0, 0,
         13'h0000, -28, 1, 0, 0, st); tot += st;
    send(13'h0055, 1'b0, 26'h0, 7, 1, 1, 1,
         13'h0000, 0, 0, 0, 1, st); tot += st;
    send(13'h0055, 1'b1, 26'h5, 4, 1, 1, 0,
         13'h0000, 0, 0, 1, 0, st); tot += st;
    send(13'h0ABC, 1'b1, 26'h0, 10, 1, 0, 1,
         13'h0000, 0, 0, 0, 1, st); tot += st;
    send(13'h0100, 1'b0, 26'h0, -5, 1, 0, 0,
         13'h0100, -5, 1, 0, 0, st); tot += st;
    send(13'h0055, 1'b0, 26'h0, 28, 0, 0, 0,
         13'h0000, 28, 0, 0, 0, st); tot += st;
    send(13'h0007, 1'b0, 26'h0, -28, 0, 0, 0,
         13'h0000, -28, 0, 0, 0, st); tot += st;
    send(13'h0007, 1'b1, 26'h0, -27, 0, 0, 0,
         13'h0008, -27, 0, 0, 0, st); tot += st;
    send(13'h1FFF, 1'b1, 26'h1, -1, 1, 0, 0,
         13'h0000, 0, 1, 0, 0, st); tot += st;
    idle();
    chk("full_rate_stalls", 64'(tot), 64'd0);
    drain();

    // backpressure: two held, third waits
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    fork
      begin
        send(13'h0011, 1'b0, 26'h0, 1, 0, 0, 0,
             13'h0011, 1, 0, 0, 0, st);
        send(13'h0022, 1'b0, 26'h0, 2, 0, 0, 0,
             13'h0022, 2, 0, 0, 0, st);
        send(13'h0033, 1'b0, 26'h0, 3, 0, 0, 0,
             13'h0033, 3, 0, 0, 0, st);
        idle();
      end
      begin
        repeat (6) @(negedge clk);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_accepted", 64'(q.size()), 64'd2);
        chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_in_ready", 64'(bus.in_ready), 64'd1);
        chk("bp_rel_v1", 64'(bus.out_valid), 64'd1);
        @(negedge clk);
        chk("bp_rel_v2", 64'(bus.out_valid), 64'd1);
        @(negedge clk);
        chk("bp_rel_v3", 64'(bus.out_valid), 64'd1);
      end
    join
    drain();

    // reset with two beats in flight
    send(13'h0044, 1'b0, 26'h0, 4, 0, 0, 0,
         13'h0044, 4, 0, 0, 0, st);
    send(13'h0066, 1'b0, 26'h0, 6, 0, 0, 0,
         13'h0066, 6, 0, 0, 0, st);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    q.delete();
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_stale", 64'(bus.out_valid), 64'd0);
    end
    send(13'h0777, 1'b1, 26'h2, -3, 1, 0, 0,
         13'h0778, -3, 1, 0, 0, st);
    idle();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
